// File: rtl/pd_event_counter.sv
// rtl/pd_event_counter.sv - edge-detected, saturating BCD event counter for the digit-pattern detector
// Optional alarm stretcher compiled in with PD_ALARM_EN.

module pd_bcd_counter (
   input  logic       clk,
   input  logic       reset,
   input  logic       clear,
   input  logic       inc,
   output logic [3:0] tens,
   output logic [3:0] ones,
   output logic       overflow
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tens     <= 4'd0;
         ones     <= 4'd0;
         overflow <= 1'b0;
      end else if (clear) begin
         tens     <= 4'd0;
         ones     <= 4'd0;
         overflow <= 1'b0;
      end else if (inc) begin
         // Saturate at 99 rather than wrap; the sticky flag records the lost event.
         if (ones < 4'd9) begin
            ones <= ones + 4'd1;
         end else if (tens < 4'd9) begin
            ones <= 4'd0;
            tens <= tens + 4'd1;
         end else begin
            overflow <= 1'b1;
         end
      end
   end

endmodule

module pd_event_counter #(
   parameter int STRETCH = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       clear,
   input  logic       pattern1,
   input  logic       pattern2,
   output logic [3:0] count1_tens,
   output logic [3:0] count1_ones,
   output logic [3:0] count2_tens,
   output logic [3:0] count2_ones,
   output logic [1:0] last_pattern,
   output logic       event_pulse,
   output logic       overflow1,
   output logic       overflow2,
   output logic       alarm
);

   if (STRETCH < 1 || STRETCH > 255) begin : g_bad_stretch
      $error("pd_event_counter: STRETCH out of range 1..255");
   end

   logic prev1;
   logic prev2;
   logic ev1;
   logic ev2;

   // prev resets high so a level already asserted at reset release is not an event.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prev1 <= 1'b1;
         prev2 <= 1'b1;
      end else begin
         prev1 <= pattern1;
         prev2 <= pattern2;
      end
   end

   assign ev1 = pattern1 & ~prev1;
   assign ev2 = pattern2 & ~prev2;

   pd_bcd_counter u_count1 (
      .clk      (clk),
      .reset    (reset),
      .clear    (clear),
      .inc      (ev1),
      .tens     (count1_tens),
      .ones     (count1_ones),
      .overflow (overflow1)
   );

   pd_bcd_counter u_count2 (
      .clk      (clk),
      .reset    (reset),
      .clear    (clear),
      .inc      (ev2),
      .tens     (count2_tens),
      .ones     (count2_ones),
      .overflow (overflow2)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_pattern <= 2'b00;
         event_pulse  <= 1'b0;
      end else if (clear) begin
         last_pattern <= 2'b00;
         event_pulse  <= 1'b0;
      end else begin
         event_pulse <= ev1 | ev2;
         if (ev1 | ev2) begin
            last_pattern <= {ev2, ev1};
         end
      end
   end

`ifdef PD_ALARM_EN
   localparam logic [7:0] STRETCH_LOAD = 8'(STRETCH);

   logic [7:0] alarm_cnt;

   // A retrigger reloads rather than accumulates, so the hold is measured from the last ev2.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         alarm_cnt <= 8'd0;
      end else if (clear) begin
         alarm_cnt <= 8'd0;
      end else if (ev2) begin
         alarm_cnt <= STRETCH_LOAD;
      end else if (alarm_cnt != 8'd0) begin
         alarm_cnt <= alarm_cnt - 8'd1;
      end
   end

   assign alarm = (alarm_cnt != 8'd0);
`else
   assign alarm = 1'b0;
`endif

endmodule

// File: tb/tb_pd_event_counter.sv
// tb/tb_pd_event_counter.sv - directed self-checking bench for pd_event_counter
module tb_pd_event_counter;

   logic       clk;
   logic       reset;
   logic       clear;
   logic       pattern1;
   logic       pattern2;
   logic [3:0] count1_tens;
   logic [3:0] count1_ones;
   logic [3:0] count2_tens;
   logic [3:0] count2_ones;
   logic [1:0] last_pattern;
   logic       event_pulse;
   logic       overflow1;
   logic       overflow2;
   logic       alarm;

   int tests;
   int failed;

   pd_event_counter #(.STRETCH(8)) dut (
      .clk          (clk),
      .reset        (reset),
      .clear        (clear),
      .pattern1     (pattern1),
      .pattern2     (pattern2),
      .count1_tens  (count1_tens),
      .count1_ones  (count1_ones),
      .count2_tens  (count2_tens),
      .count2_ones  (count2_ones),
      .last_pattern (last_pattern),
      .event_pulse  (event_pulse),
      .overflow1    (overflow1),
      .overflow2    (overflow2),
      .alarm        (alarm)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_clear();
      clear = 1'b1;
      tick();
      clear = 1'b0;
   endtask

   task automatic pulse(input logic p1, input logic p2);
      pattern1 = p1;
      pattern2 = p2;
      tick();
      pattern1 = 1'b0;
      pattern2 = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      reset    = 1'b1;
      clear    = 1'b0;
      pattern1 = 1'b1;
      pattern2 = 1'b0;
      tick();
      tick();
      tests++;
      if ({count1_tens, count1_ones, count2_tens, count2_ones, last_pattern, event_pulse,
           overflow1, overflow2, alarm} !== 23'd0) begin
         failed++;
         $display("FAIL reset_state: got c1=%h%h c2=%h%h last=%b ev=%b ov=%b%b al=%b, need all 0",
                  count1_tens, count1_ones, count2_tens, count2_ones, last_pattern,
                  event_pulse, overflow1, overflow2, alarm);
      end
      reset = 1'b0;
      tick();
      tick();
      tests++;
      if ({count1_tens, count1_ones} !== 8'h00 || event_pulse !== 1'b0) begin
         failed++;
         $display("FAIL held_high_at_release: got c1=%h%h ev=%b, need 00 ev=0",
                  count1_tens, count1_ones, event_pulse);
      end
      pattern1 = 1'b0;
      tick();
      pattern1 = 1'b1;
      tick();
      tests++;
      if ({count1_tens, count1_ones} !== 8'h01 || event_pulse !== 1'b1 || last_pattern !== 2'b01) begin
         failed++;
         $display("FAIL first_rise: got c1=%h%h ev=%b last=%b, need 01 ev=1 last=01",
                  count1_tens, count1_ones, event_pulse, last_pattern);
      end
      tick();
      tests++;
      if (event_pulse !== 1'b0) begin
         failed++;
         $display("FAIL pulse_one_cycle: got ev=%b, need 0", event_pulse);
      end
      tick();
      tests++;
      if ({count1_tens, count1_ones} !== 8'h01 || last_pattern !== 2'b01) begin
         failed++;
         $display("FAIL held_level_once: got c1=%h%h last=%b, need 01 last=01",
                  count1_tens, count1_ones, last_pattern);
      end
      pattern1 = 1'b0;
      tick();
   endtask

   task automatic test_ten_pulses();
      do_clear();
      for (int i = 0; i < 10; i++) pulse(1'b1, 1'b0);
      tests++;
      if ({count1_tens, count1_ones} !== 8'h10 || overflow1 !== 1'b0 || last_pattern !== 2'b01) begin
         failed++;
         $display("FAIL ten_pulses: got c1=%h%h ov1=%b last=%b, need 10 ov1=0 last=01",
                  count1_tens, count1_ones, overflow1, last_pattern);
      end
   endtask

   task automatic test_overflow();
      do_clear();
      for (int i = 0; i < 99; i++) pulse(1'b0, 1'b1);
      tests++;
      if ({count2_tens, count2_ones} !== 8'h99 || overflow2 !== 1'b0) begin
         failed++;
         $display("FAIL count_99: got c2=%h%h ov2=%b, need 99 ov2=0",
                  count2_tens, count2_ones, overflow2);
      end
      pulse(1'b0, 1'b1);
      tests++;
      if ({count2_tens, count2_ones} !== 8'h99 || overflow2 !== 1'b1 || last_pattern !== 2'b10) begin
         failed++;
         $display("FAIL saturate_100: got c2=%h%h ov2=%b last=%b, need 99 ov2=1 last=10",
                  count2_tens, count2_ones, overflow2, last_pattern);
      end
      pulse(1'b0, 1'b1);
      tests++;
      if ({count2_tens, count2_ones} !== 8'h99 || overflow2 !== 1'b1) begin
         failed++;
         $display("FAIL saturate_101: got c2=%h%h ov2=%b, need 99 ov2=1",
                  count2_tens, count2_ones, overflow2);
      end
      do_clear();
      tests++;
      if ({count2_tens, count2_ones} !== 8'h00 || overflow2 !== 1'b0 || last_pattern !== 2'b00) begin
         failed++;
         $display("FAIL clear_after_ov: got c2=%h%h ov2=%b last=%b, need 00 ov2=0 last=00",
                  count2_tens, count2_ones, overflow2, last_pattern);
      end
   endtask

   task automatic test_same_cycle();
      do_clear();
      pulse(1'b1, 1'b0);
      pattern1 = 1'b1;
      pattern2 = 1'b1;
      tick();
      tests++;
      if ({count1_tens, count1_ones, count2_tens, count2_ones} !== 16'h0201 ||
          last_pattern !== 2'b11 || event_pulse !== 1'b1) begin
         failed++;
         $display("FAIL same_cycle: got c1=%h%h c2=%h%h last=%b ev=%b, need 02 01 last=11 ev=1",
                  count1_tens, count1_ones, count2_tens, count2_ones, last_pattern, event_pulse);
      end
      tick();
      tests++;
      if (event_pulse !== 1'b0 || last_pattern !== 2'b11) begin
         failed++;
         $display("FAIL same_cycle_single_pulse: got ev=%b last=%b, need ev=0 last=11",
                  event_pulse, last_pattern);
      end
      pattern1 = 1'b0;
      pattern2 = 1'b0;
      tick();
   endtask

   task automatic test_clear_priority();
      do_clear();
      pattern1 = 1'b1;
      clear    = 1'b1;
      tick();
      clear = 1'b0;
      tests++;
      if ({count1_tens, count1_ones} !== 8'h00 || event_pulse !== 1'b0) begin
         failed++;
         $display("FAIL clear_priority: got c1=%h%h ev=%b, need 00 ev=0",
                  count1_tens, count1_ones, event_pulse);
      end
      tick();
      tests++;
      if ({count1_tens, count1_ones} !== 8'h00 || event_pulse !== 1'b0) begin
         failed++;
         $display("FAIL clear_samples_prev: got c1=%h%h ev=%b, need 00 ev=0",
                  count1_tens, count1_ones, event_pulse);
      end
      pattern1 = 1'b0;
      tick();
   endtask

   task automatic test_alarm();
      int highs;
      do_clear();
`ifdef PD_ALARM_EN
      pattern2 = 1'b1;
      tick();
      pattern2 = 1'b0;
      highs = 0;
      for (int i = 0; i < 12; i++) begin
         if (alarm === 1'b1) highs++;
         tick();
      end
      tests++;
      if (highs !== 8) begin
         failed++;
         $display("FAIL alarm_width: got %0d high cycles, need 8", highs);
      end
      // Retrigger five cycles after the first event: 5 + 8 = 13 high cycles.
      pattern2 = 1'b1;
      tick();
      pattern2 = 1'b0;
      tick();
      tick();
      tick();
      tick();
      pattern2 = 1'b1;
      tick();
      pattern2 = 1'b0;
      highs = 5;
      for (int i = 0; i < 7; i++) begin
         if (alarm === 1'b1) highs++;
         tick();
      end
      tests++;
      if (alarm !== 1'b1 || highs !== 12) begin
         failed++;
         $display("FAIL alarm_retrigger_hold: got alarm=%b highs=%0d, need alarm=1 highs=12",
                  alarm, highs);
      end
      tick();
      tests++;
      if (alarm !== 1'b0) begin
         failed++;
         $display("FAIL alarm_retrigger_end: got alarm=%b, need 0", alarm);
      end
      pulse(1'b0, 1'b1);
      do_clear();
      tests++;
      if (alarm !== 1'b0) begin
         failed++;
         $display("FAIL alarm_clear: got alarm=%b, need 0", alarm);
      end
`else
      highs = 0;
      pulse(1'b0, 1'b1);
      for (int i = 0; i < 4; i++) begin
         if (alarm !== 1'b0) highs++;
         tick();
      end
      tests++;
      if (highs !== 0 || {count2_tens, count2_ones} !== 8'h01) begin
         failed++;
         $display("FAIL alarm_disabled: got %0d alarm-high cycles c2=%h%h, need 0 and 01",
                  highs, count2_tens, count2_ones);
      end
`endif
   endtask

   task automatic test_async_reset();
      do_clear();
      for (int i = 0; i < 37; i++) pulse(1'b1, 1'b0);
      for (int i = 0; i < 12; i++) pulse(1'b0, 1'b1);
      tests++;
      if ({count1_tens, count1_ones, count2_tens, count2_ones} !== 16'h3712) begin
         failed++;
         $display("FAIL pre_reset_counts: got c1=%h%h c2=%h%h, need 37 12",
                  count1_tens, count1_ones, count2_tens, count2_ones);
      end
`ifdef PD_ALARM_EN
      tests++;
      if (alarm !== 1'b1) begin
         failed++;
         $display("FAIL pre_reset_alarm: got alarm=%b, need 1", alarm);
      end
`endif
      #2;
      reset = 1'b1;
      #1;
      tests++;
      if ({count1_tens, count1_ones, count2_tens, count2_ones, last_pattern, event_pulse,
           overflow1, overflow2, alarm} !== 23'd0) begin
         failed++;
         $display("FAIL async_reset: got c1=%h%h c2=%h%h last=%b ev=%b ov=%b%b al=%b, need all 0",
                  count1_tens, count1_ones, count2_tens, count2_ones, last_pattern,
                  event_pulse, overflow1, overflow2, alarm);
      end
      tick();
      reset = 1'b0;
      tick();
   endtask

   initial begin
      tests  = 0;
      failed = 0;
      test_reset();
      test_ten_pulses();
      test_overflow();
      test_same_cycle();
      test_clear_priority();
      test_alarm();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
